// File: rtl/pipe_abs_sub.sv
// Pipelined unsigned absolute-difference unit: out_diff = |in_a - in_b|.
// Each stage runs one 4-bit carry-lookahead slice of a + ~b + c. The carry and
// the nibbles already finished are registered into the next stage. The operand
// nibbles that are still waiting are delayed alongside them, so the operands
// are skewed. A last register stage turns the two's-complement difference into
// a magnitude and generates the sign and zero flags.
`timescale 1ns/1ps

module pipe_abs_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_neg,
  output logic             out_zero
);

  localparam int NSTG = WIDTH / 4;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // 4-bit carry-lookahead adder slice: returns {carry_out, sum[3:0]}
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // The whole pipeline moves as one; a stalled output freezes every stage
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    // Operand bits not yet consumed when they enter this stage (nibble k upward)
    localparam int IW = WIDTH - 4*k;

    logic [IW-1:0]  a_in;
    logic [IW-1:0]  b_in;
    logic           c_in;
    logic           v_in;
    logic [4:0]     res;
    logic [4*k+3:0] d_nx;

    logic           v_q;
    logic           c_q;
    logic [4*k+3:0] d_q;

    if (k == 0) begin : g_head
      // First slice subtracts straight from the ports; carry-in 1 completes ~b + 1
      assign a_in = in_a;
      assign b_in = in_b;
      assign c_in = 1'b1;
      assign v_in = in_valid;
      assign d_nx = res[3:0];
    end else begin : g_body
      assign a_in = g_stg[k-1].g_fwd.a_q;
      assign b_in = g_stg[k-1].g_fwd.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;
      assign d_nx = {res[3:0], g_stg[k-1].d_q};
    end

    assign res = cla4(a_in[3:0], ~b_in[3:0], c_in);

    // Register this stage's valid bit, its carry-out and the diff nibbles finished so far
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        d_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= res[4];
        d_q <= d_nx;
      end
    end

    if (k < NSTG - 1) begin : g_fwd
      logic [IW-5:0] a_q;
      logic [IW-5:0] b_q;

      // Delay the operand nibbles that later stages still need
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[IW-1:4];
          b_q <= b_in[IW-1:4];
        end
      end
    end
  end

  // A missing final carry means a borrow, so the raw difference is negative
  logic [WIDTH-1:0] fin_d;
  logic             fin_borrow;
  logic             fin_valid;
  logic [WIDTH-1:0] fin_mag;

  assign fin_d      = g_stg[NSTG-1].d_q;
  assign fin_borrow = ~g_stg[NSTG-1].c_q;
  assign fin_valid  = g_stg[NSTG-1].v_q;
  assign fin_mag    = fin_borrow ? (~fin_d + ONE) : fin_d;

  // Output register: the result data changes only when a valid result arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_neg   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (adv) begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        out_diff <= fin_mag;
        out_neg  <= fin_borrow;
        out_zero <= (fin_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipe_abs_sub.sv
// Directed and randomised bench for pipe_abs_sub at WIDTH=16. Results are matched
// in order against a queue of expected values. A monitor compares every handshake.
`timescale 1ns/1ps

module tb_pipe_abs_sub;

  typedef struct packed {
    logic [15:0] diff;
    logic        neg;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_diff;
  logic        out_neg;
  logic        out_zero;

  exp_t exp_q[$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   run_len     = 0;
  int   max_run     = 0;
  bit   rand_done   = 0;

  pipe_abs_sub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_neg   (out_neg),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    check_count++;
    if (got === want) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Independent reference: magnitude of the difference plus the two flags
  function automatic exp_t modelResult(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.diff = (a >= b) ? (a - b) : (b - a);
    e.neg  = (a < b);
    e.zero = (a == b);
    return e;
  endfunction

  // Present one operand pair and wait (bounded) until it is accepted
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] d, input logic neg, input logic zero);
    exp_t e;
    bit   taken;
    taken    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      if (taken) break;
    end
    in_valid = 1'b0;
    if (!taken) checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    else begin
      e.diff = d;
      e.neg  = neg;
      e.zero = zero;
      exp_q.push_back(e);
    end
  endtask

  // Wait (bounded) for every expected result to leave, then idle a few cycles
  task automatic waitDrain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput(tag, exp_q.size(), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Count accepted-edge cycles from acceptance until out_valid rises
  task automatic measureLatency(input string tag);
    int n;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, n, 32'd5);
  endtask

  // Monitor: every output handshake is compared with the oldest expected result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("diff", {16'd0, out_diff}, {16'd0, e.diff});
        checkOutput("neg",  {31'd0, out_neg},  {31'd0, e.neg});
        checkOutput("zero", {31'd0, out_zero}, {31'd0, e.zero});
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_diff",  {16'd0, out_diff},  32'd0);
    checkOutput("rst_out_neg",   {31'd0, out_neg},   32'd0);
    checkOutput("rst_out_zero",  {31'd0, out_zero},  32'd0);
    checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk);
    #1;

    $display("[TB] single op and latency");
    applyStimulus(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
    measureLatency("latency_first");
    waitDrain("drain_single");

    $display("[TB] boundary operands");
    applyStimulus(16'h0001, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h0FFF, 16'h1000, 16'h0001, 1'b1, 1'b0);
    waitDrain("drain_boundary");

    $display("[TB] eight back-to-back pairs");
    max_run = 0;
    applyStimulus(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0);
    applyStimulus(16'h0001, 16'h0010, 16'h000F, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h7FFF, 16'h8000, 16'h0001, 1'b1, 1'b0);
    applyStimulus(16'hF0F0, 16'h0F0F, 16'hE1E1, 1'b0, 1'b0);
    applyStimulus(16'h1000, 16'h0FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h5555, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
    waitDrain("drain_b2b");
    checkOutput("b2b_consecutive", max_run, 32'd8);

    $display("[TB] output stall");
    applyStimulus(16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0);
    applyStimulus(16'h0002, 16'h0100, 16'h00FE, 1'b1, 1'b0);
    applyStimulus(16'h3000, 16'h1000, 16'h2000, 1'b0, 1'b0);
    applyStimulus(16'h1000, 16'h3000, 16'h2000, 1'b1, 1'b0);
    applyStimulus(16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b1);
    applyStimulus(16'hC350, 16'h2710, 16'h9C40, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", {31'd0, in_ready},  32'd0);
      checkOutput("stall_valid",    {31'd0, out_valid}, 32'd1);
      checkOutput("stall_diff",     {16'd0, out_diff},  {16'd0, exp_q[0].diff});
      checkOutput("stall_neg",      {31'd0, out_neg},   {31'd0, exp_q[0].neg});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain("drain_stall");

    $display("[TB] reset with results in flight");
    applyStimulus(16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0);
    applyStimulus(16'h0002, 16'h0100, 16'h00FE, 1'b1, 1'b0);
    applyStimulus(16'h3000, 16'h1000, 16'h2000, 1'b0, 1'b0);
    applyStimulus(16'h1000, 16'h3000, 16'h2000, 1'b1, 1'b0);
    applyStimulus(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    applyStimulus(16'h0003, 16'h0005, 16'h0002, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_diff",  {16'd0, out_diff},  32'd0);
    checkOutput("midrst_neg",   {31'd0, out_neg},   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'h4321, 16'h1234, 16'h30ED, 1'b0, 1'b0);
    measureLatency("latency_after_rst");
    waitDrain("drain_after_rst");

    $display("[TB] random traffic with random backpressure");
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [15:0] a;
          logic [15:0] b;
          exp_t        e;
          a = 16'($urandom);
          b = 16'($urandom);
          case ($urandom_range(0, 7))
            0: a = 16'h0000;
            1: a = 16'hFFFF;
            2: b = a;
            3: b = 16'hFFFF;
            default: ;
          endcase
          e = modelResult(a, b);
          applyStimulus(a, b, e.diff, e.neg, e.zero);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    waitDrain("drain_random");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
